// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath /
// shared memory port.
//   opcode, br_taken   : instruction class and branch outcome from the datapath
//   mem_ready          : memory completes the current request this cycle
//   mem_req/rw/addr_sel: memory request, direction and address source
//   ir_we, pc_we, pc_sel, regw_en : datapath enables and PC source
//   retire             : pulse on the last cycle of each instruction
//   state, fault, illegal : sequencer status
// master = sequencer side, slave = datapath/memory side.
interface multicycle_sequencer_if;
    logic [4:0] opcode;
    logic       br_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_rw;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       regw_en;
    logic       retire;
    logic [2:0] state;
    logic       fault;
    logic       illegal;

    modport master (
        input  opcode, br_taken, mem_ready,
        output mem_req, mem_rw, mem_addr_sel, ir_we, pc_we, pc_sel,
               regw_en, retire, state, fault, illegal
    );

    modport slave (
        output opcode, br_taken, mem_ready,
        input  mem_req, mem_rw, mem_addr_sel, ir_we, pc_we, pc_sel,
               regw_en, retire, state, fault, illegal
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I sequencer with one shared variable-latency memory port.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the PC, IR, memory and register-file enables.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset; all outputs forced low while high
//   bus : multicycle_sequencer_if.master (see interface header)
//
// state  | meaning
// FETCH  | read instruction at PC; on mem_ready load IR and PC+4
// DECODE | classify opcode, latch class (illegal -> HALT)
// EXEC   | ALU step; branches and jumps finish here
// MEM    | data access at ALU address; store finishes here
// WB     | register-file write, instruction retires
// HALT   | memory timeout or illegal opcode; left only through rst
module multicycle_sequencer #(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_HALT   = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP
    } class_t;

    // Last wait cycle a request may spend without mem_ready.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX - 1);

    state_t     state_q, state_d;
    class_t     class_q, class_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       fault_q, fault_d;
    logic       illegal_q, illegal_d;

    logic mem_req, mem_rw, mem_addr_sel, ir_we, pc_we, pc_sel, regw_en, retire;

    function automatic class_t classify(input logic [4:0] op);
        case (op)
            5'b01100: classify = CL_R;
            5'b00100: classify = CL_I;
            5'b00000: classify = CL_LOAD;
            5'b01000: classify = CL_STORE;
            5'b11000: classify = CL_BRANCH;
            5'b11011: classify = CL_JUMP;
            5'b11001: classify = CL_JUMP;
            default:  classify = CL_NONE;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            class_q    <= CL_NONE;
            wait_cnt_q <= 8'd0;
            fault_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        fault_d      = fault_q;
        illegal_d    = illegal_q;
        mem_req      = 1'b0;
        mem_rw       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        regw_en      = 1'b0;
        retire       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                class_d = classify(bus.opcode);
                if (class_d == CL_NONE) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CL_R, CL_I:        state_d = ST_WB;
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    CL_BRANCH: begin
                        pc_we   = bus.br_taken;
                        pc_sel  = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CL_JUMP: begin
                        pc_we   = 1'b1;
                        pc_sel  = 1'b1;
                        regw_en = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    // No legal class latched: cannot happen after DECODE.
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_rw       = (class_q == CL_STORE);
                if (bus.mem_ready) begin
                    if (class_q == CL_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                regw_en = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // Wait counter: only advances while a request is outstanding; any state
    // change (including the timeout to HALT) starts the next request at zero.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = 8'd0;
        end else if (mem_req) begin
            wait_cnt_d = bus.mem_ready ? 8'd0 : wait_cnt_q + 8'd1;
        end
    end

    // The register holds FETCH during reset, so gating with rst keeps the
    // request low while rst is high and lets it rise as soon as rst falls.
    assign bus.mem_req      = mem_req      & ~rst;
    assign bus.mem_rw       = mem_rw       & ~rst;
    assign bus.mem_addr_sel = mem_addr_sel & ~rst;
    assign bus.ir_we        = ir_we        & ~rst;
    assign bus.pc_we        = pc_we        & ~rst;
    assign bus.pc_sel       = pc_sel       & ~rst;
    assign bus.regw_en      = regw_en      & ~rst;
    assign bus.retire       = retire       & ~rst;
    assign bus.fault        = fault_q      & ~rst;
    assign bus.illegal      = illegal_q    & ~rst;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    localparam logic [2:0] F = 3'b000, D = 3'b001, E = 3'b010,
                           M = 3'b011, W = 3'b100, H = 3'b111;
    localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LD = 5'b00000,
                           OP_ST = 5'b01000, OP_BR = 5'b11000, OP_JAL = 5'b11011,
                           OP_JALR = 5'b11001, OP_BAD = 5'b11111;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_sequencer_if bus ();

    multicycle_sequencer #(.MEM_WAIT_MAX(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [12:0] exp_q[$];
    string       name_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    // {state, mem_req, mem_rw, mem_addr_sel, ir_we, pc_we, pc_sel, regw_en,
    //  retire, fault, illegal}
    function automatic logic [12:0] ev(input logic [2:0] st, input logic req,
                                       input logic rw, input logic asel,
                                       input logic irwe, input logic pcwe,
                                       input logic pcsel, input logic regw,
                                       input logic ret, input logic flt,
                                       input logic ill);
        return {st, req, rw, asel, irwe, pcwe, pcsel, regw, ret, flt, ill};
    endfunction

    // Monitor: compares the DUT outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin
        logic [12:0] act, e;
        string       n;
        if (exp_q.size() > 0) begin
            act = {bus.state, bus.mem_req, bus.mem_rw, bus.mem_addr_sel, bus.ir_we,
                   bus.pc_we, bus.pc_sel, bus.regw_en, bus.retire, bus.fault,
                   bus.illegal};
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compared++;
            if (act !== e) begin
                mismatched++;
                $display("FAIL %s: got %b expected %b (st req rw asel irwe pcwe pcsel regw ret flt ill)",
                         n, act, e);
            end
        end
    end

    // One cycle of stimulus; rst changes 1ns after the edge, i.e. mid-cycle.
    task automatic step(input string name, input logic r, input logic [4:0] op,
                        input logic br, input logic rdy, input logic [12:0] e);
        @(posedge clk);
        #1;
        rst           = r;
        bus.opcode    = op;
        bus.br_taken  = br;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic fetch_ok(input string name);
        step(name, 1'b0, OP_R, 1'b0, 1'b1, ev(F,1,0,0,1,1,0,0,0,0,0));
    endtask

    task automatic fetch_wait(input string name);
        step(name, 1'b0, OP_R, 1'b0, 1'b0, ev(F,1,0,0,0,0,0,0,0,0,0));
    endtask

    // mem_ready is driven high outside FETCH/MEM to show it is ignored there.
    task automatic decode(input string name, input logic [4:0] op);
        step(name, 1'b0, op, 1'b0, 1'b1, ev(D,0,0,0,0,0,0,0,0,0,0));
    endtask

    task automatic exec_plain(input string name, input logic [4:0] op);
        step(name, 1'b0, op, 1'b0, 1'b1, ev(E,0,0,0,0,0,0,0,0,0,0));
    endtask

    task automatic wb(input string name, input logic [4:0] op);
        step(name, 1'b0, op, 1'b0, 1'b1, ev(W,0,0,0,0,0,0,1,1,0,0));
    endtask

    task automatic do_reset(input string name);
        step(name, 1'b1, OP_R, 1'b1, 1'b1, ev(F,0,0,0,0,0,0,0,0,0,0));
    endtask

    initial begin
        bus.opcode    = OP_R;
        bus.br_taken  = 1'b0;
        bus.mem_ready = 1'b1;

        do_reset("reset_0");
        do_reset("reset_1");

        // R-type, zero wait states
        fetch_ok("r_fetch");
        decode("r_decode", OP_R);
        exec_plain("r_exec", OP_R);
        wb("r_wb", OP_R);

        // I-arith
        fetch_ok("i_fetch");
        decode("i_decode", OP_I);
        exec_plain("i_exec", OP_I);
        wb("i_wb", OP_I);

        // LOAD with 3 wait states in MEM
        fetch_ok("ld_fetch");
        decode("ld_decode", OP_LD);
        exec_plain("ld_exec", OP_LD);
        for (int i = 0; i < 3; i++)
            step("ld_mem_wait", 1'b0, OP_LD, 1'b0, 1'b0, ev(M,1,0,1,0,0,0,0,0,0,0));
        step("ld_mem_ready", 1'b0, OP_LD, 1'b0, 1'b1, ev(M,1,0,1,0,0,0,0,0,0,0));
        wb("ld_wb", OP_LD);

        // STORE with two fetch wait states and one MEM wait state
        fetch_wait("st_fetch_wait");
        fetch_wait("st_fetch_wait");
        fetch_ok("st_fetch");
        decode("st_decode", OP_ST);
        exec_plain("st_exec", OP_ST);
        step("st_mem_wait", 1'b0, OP_ST, 1'b0, 1'b0, ev(M,1,1,1,0,0,0,0,0,0,0));
        step("st_mem_ready", 1'b0, OP_ST, 1'b0, 1'b1, ev(M,1,1,1,0,0,0,0,1,0,0));

        // BRANCH not taken / taken
        fetch_ok("bnt_fetch");
        decode("bnt_decode", OP_BR);
        step("bnt_exec", 1'b0, OP_BR, 1'b0, 1'b1, ev(E,0,0,0,0,0,1,0,1,0,0));
        fetch_ok("bt_fetch");
        decode("bt_decode", OP_BR);
        step("bt_exec", 1'b0, OP_BR, 1'b1, 1'b1, ev(E,0,0,0,0,1,1,0,1,0,0));

        // JAL / JALR
        fetch_ok("jal_fetch");
        decode("jal_decode", OP_JAL);
        step("jal_exec", 1'b0, OP_JAL, 1'b0, 1'b1, ev(E,0,0,0,0,1,1,1,1,0,0));
        fetch_ok("jalr_fetch");
        decode("jalr_decode", OP_JALR);
        step("jalr_exec", 1'b0, OP_JALR, 1'b0, 1'b1, ev(E,0,0,0,0,1,1,1,1,0,0));

        // FETCH timeout: 16 wait cycles, then HALT with fault, stays there
        for (int i = 0; i < 16; i++) fetch_wait("to_fetch_wait");
        step("to_halt", 1'b0, OP_R, 1'b0, 1'b0, ev(H,0,0,0,0,0,0,0,0,1,0));
        step("to_halt_ready", 1'b0, OP_R, 1'b0, 1'b1, ev(H,0,0,0,0,0,0,0,0,1,0));
        step("to_halt_stay", 1'b0, OP_R, 1'b0, 1'b0, ev(H,0,0,0,0,0,0,0,0,1,0));
        do_reset("reset_after_fault");

        // mem_ready on the limit cycle wins, then an illegal opcode
        for (int i = 0; i < 15; i++) fetch_wait("lim_fetch_wait");
        fetch_ok("lim_fetch_ready");
        decode("ill_decode", OP_BAD);
        step("ill_halt", 1'b0, OP_BAD, 1'b0, 1'b1, ev(H,0,0,0,0,0,0,0,0,0,1));
        step("ill_halt_stay", 1'b0, OP_BAD, 1'b0, 1'b1, ev(H,0,0,0,0,0,0,0,0,0,1));
        do_reset("reset_after_illegal");

        // Reset mid-MEM with a pending request, then a normal instruction
        fetch_ok("rm_fetch");
        decode("rm_decode", OP_LD);
        exec_plain("rm_exec", OP_LD);
        step("rm_mem_wait", 1'b0, OP_LD, 1'b0, 1'b0, ev(M,1,0,1,0,0,0,0,0,0,0));
        step("rm_reset", 1'b1, OP_LD, 1'b0, 1'b0, ev(F,0,0,0,0,0,0,0,0,0,0));
        fetch_ok("rm_refetch");
        decode("rm_r_decode", OP_R);
        exec_plain("rm_r_exec", OP_R);
        wb("rm_r_wb", OP_R);

        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
